// File: rtl/neuron_mac_q88.sv
// Neuron pre-activation stage: streams Q8.8 weight/activation pairs,
// accumulates the full-precision signed products, adds the bias, rounds
// half-up and saturates back to Q8.8. One packet (ended by in_last)
// yields one out_x word, presented to the sigmoid stage over valid/ready.
module neuron_mac_q88 #(
    parameter int BITS     = 16,
    parameter int FRAC     = 8,
    parameter int ACC_BITS = 40
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_w,
    input  logic [BITS-1:0] in_a,
    input  logic            in_last,
    input  logic [BITS-1:0] bias,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_x,
    output logic            out_sat
);

    // One guard bit above the accumulator so the bias/rounding add in the
    // finish cycle cannot wrap on its own.
    localparam int SW = ACC_BITS + 1;

    localparam logic signed [SW-1:0] RND_C =
        {{(SW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [SW-1:0] MAX_C =
        {{(SW-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_C =
        {{(SW-BITS+1){1'b1}}, {(BITS-1){1'b0}}};
    localparam logic [BITS-1:0] SAT_HI_C = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [BITS-1:0] SAT_LO_C = {1'b1, {(BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_FIN = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    state_t                      state_r;
    logic signed [ACC_BITS-1:0]  acc_r;
    logic                        in_ready_r;
    logic                        out_valid_r;
    logic [BITS-1:0]             out_x_r;
    logic                        out_sat_r;

    logic signed [2*BITS-1:0]    prod_s;
    logic signed [ACC_BITS-1:0]  prod_ext_s;
    logic signed [SW-1:0]        bias_sh_s;
    logic signed [SW-1:0]        sum_s;
    logic signed [SW-1:0]        r_s;
    logic [BITS-1:0]             res_x_s;
    logic                        res_sat_s;

    // Full-width signed product and the rounded, saturated finish value.
    always_comb begin
        prod_s     = $signed(in_w) * $signed(in_a);
        prod_ext_s = {{(ACC_BITS-2*BITS){prod_s[2*BITS-1]}}, prod_s};
        bias_sh_s  = {{(SW-BITS-FRAC){bias[BITS-1]}}, bias, {FRAC{1'b0}}};
        sum_s      = {acc_r[ACC_BITS-1], acc_r} + bias_sh_s + RND_C;
        r_s        = sum_s >>> FRAC;
        res_x_s    = r_s[BITS-1:0];
        res_sat_s  = 1'b0;
        if (r_s > MAX_C) begin
            res_x_s   = SAT_HI_C;
            res_sat_s = 1'b1;
        end else if (r_s < MIN_C) begin
            res_x_s   = SAT_LO_C;
            res_sat_s = 1'b1;
        end else begin
            res_x_s   = r_s[BITS-1:0];
            res_sat_s = 1'b0;
        end
    end

    // Packet sequencing: accumulate beats, finish once, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_ACC;
            acc_r       <= {ACC_BITS{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_x_r     <= {BITS{1'b0}};
            out_sat_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_ACC: begin
                    if (in_valid && in_ready_r) begin
                        acc_r <= acc_r + prod_ext_s;
                        if (in_last) begin
                            state_r    <= ST_FIN;
                            in_ready_r <= 1'b0;
                        end
                    end
                end
                ST_FIN: begin
                    out_x_r     <= res_x_s;
                    out_sat_r   <= res_sat_s;
                    out_valid_r <= 1'b1;
                    state_r     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        acc_r       <= {ACC_BITS{1'b0}};
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_ACC;
                    end
                end
                default: begin
                    state_r     <= ST_ACC;
                    acc_r       <= {ACC_BITS{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_x     = out_x_r;
    assign out_sat   = out_sat_r;

endmodule
